// File: rtl/qix_rom_loader.sv
// qix_rom_loader: splits HPS ROM download bytes into per-CPU ROM write strobes
// and checks that a complete image of the expected length arrived.
module qix_rom_loader #(
  parameter logic [7:0] ROM_INDEX      = 8'd0,
  parameter int         EXPECTED_BYTES = 36864
) (
  input  logic        clk_20m,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  output logic [13:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        data_cpu_we,
  output logic        video_cpu_we,
  output logic        sound_cpu_we,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error
);
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;
  state_t      state_q, state_d;
  logic        wr_prev_q, dl_prev_q, ovf_q, ovf_d, done_q, done_d, err_q, err_d;
  logic [15:0] count_q, count_d, count_base;
  logic [13:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [2:0]  we_q, we_d;
  logic        dl_match, start, accept, in_data, in_video, in_sound, past_end, check_ok;
  assign dl_match   = ioctl_download && (ioctl_index == ROM_INDEX);
  assign start      = dl_match && !dl_prev_q && (state_q == IDLE || state_q == DONE);
  assign accept     = dl_match && ioctl_wr && !wr_prev_q && (state_q == LOAD || start);
  assign in_data    = ioctl_addr < 25'h4000;
  assign in_video   = !in_data && ioctl_addr < 25'h8000;
  assign in_sound   = ioctl_addr >= 25'h8000 && ioctl_addr < 25'h9000;
  assign past_end   = ioctl_addr >= 25'h9000;
  assign check_ok   = count_q == 16'(EXPECTED_BYTES) && !ovf_q;
  assign count_base = start ? 16'd0 : count_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = start ? LOAD : state_q;
      LOAD:       state_d = dl_match ? LOAD : CHECK;
      CHECK:      state_d = DONE;
      default:    state_d = IDLE;
    endcase
    count_d = (accept && count_base != 16'hFFFF) ? count_base + 16'd1 : count_base;
    ovf_d   = (ovf_q && !start) || (accept && past_end);
    done_d  = start ? 1'b0 : (state_q == CHECK) ? check_ok : done_q;
    err_d   = start ? 1'b0 : (state_q == CHECK) ? !check_ok : err_q;
    we_d    = accept ? {in_sound, in_video, in_data} : 3'b000;
    addr_d  = accept ? (in_sound ? {2'b00, ioctl_addr[11:0]} : ioctl_addr[13:0]) : addr_q;
    data_d  = accept ? ioctl_data : data_q;
  end
  // Edge detectors come out of reset "high" so a download or strobe already
  // in progress when reset releases is not mistaken for a fresh start.
  always_ff @(posedge clk_20m or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      wr_prev_q <= 1'b1;
      dl_prev_q <= 1'b1;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      we_q      <= '0;
    end else begin
      state_q   <= state_d;
      wr_prev_q <= ioctl_wr;
      dl_prev_q <= dl_match;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      we_q      <= we_d;
    end
  end
  assign rom_addr     = addr_q;
  assign rom_data     = data_q;
  assign data_cpu_we  = we_q[0];
  assign video_cpu_we = we_q[1];
  assign sound_cpu_we = we_q[2];
  assign load_done    = done_q;
  assign load_error   = err_q;
  assign cpu_hold     = !(state_q == DONE && done_q);
endmodule
